// File: rtl/pll_spi_master.sv
// SPI master for the PLL register port: each command is a set-address frame
// followed by a write-data or read-data frame, completed by a level if_done.
module pll_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_reset,
  input  logic       if_read,
  input  logic       if_write,
  input  logic [7:0] if_addr,
  input  logic [7:0] if_wdata,
  output logic [7:0] if_rdata,
  output logic       if_done,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned WORD_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(16);
  localparam logic [BIT_W-1:0] SLOT_TAIL = BIT_W'(17);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FRAME_A = 3'd1,
    GAP     = 3'd2,
    FRAME_B = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    slot_q, slot_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [7:0]          rdata_d;
  logic                done_d;
  logic                sclk_d;
  logic                cs_n_d;
  logic                mosi_d;
  logic [WORD_W-1:0]   word_b;

  assign word_b = wr_q ? {8'h40, wdata_q} : {8'h80, 8'h00};

  // Slot 0 is setup, slots 1..16 carry bits 15..0 (sclk high then low), slot 17 is the tail.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = if_rdata;
    done_d  = 1'b0;
    sclk_d  = spi_sclk;
    cs_n_d  = spi_cs_n;
    mosi_d  = spi_mosi;

    if (if_reset) begin
      state_d = IDLE;
      div_d   = '0;
      slot_d  = '0;
      sclk_d  = 1'b0;
      cs_n_d  = 1'b1;
      mosi_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_d  = if_addr;
          wdata_d = if_wdata;
          rd_d    = if_read;
          wr_d    = if_write;
          if (if_write || if_read) begin
            state_d = FRAME_A;
            shreg_d = {8'h00, if_addr};
            mosi_d  = 1'b0;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            div_d   = '0;
            slot_d  = '0;
          end else begin
            state_d = DONE;
          end
        end

        FRAME_A, FRAME_B: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (slot_q == '0) begin
              slot_d = BIT_W'(1);
              sclk_d = 1'b1;
              rx_d   = {rx_q[6:0], spi_miso};
            end else if (slot_q == SLOT_TAIL) begin
              cs_n_d = 1'b1;
              sclk_d = 1'b0;
              mosi_d = 1'b0;
              slot_d = '0;
              if (state_q == FRAME_A) begin
                state_d = GAP;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
                if (rd_q && !wr_q) begin
                  rdata_d = rx_q;
                end
              end
            end else if (spi_sclk) begin
              sclk_d  = 1'b0;
              shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
              mosi_d  = shreg_q[WORD_W-2];
            end else begin
              slot_d = slot_q + BIT_W'(1);
              if (slot_q != SLOT_LAST) begin
                sclk_d = 1'b1;
                rx_d   = {rx_q[6:0], spi_miso};
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end

        GAP: begin
          if (div_q == GAP_LAST) begin
            state_d = FRAME_B;
            shreg_d = word_b;
            mosi_d  = word_b[WORD_W-1];
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            rx_d    = '0;
            div_d   = '0;
            slot_d  = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end

        DONE: begin
          done_d = 1'b1;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // The first shifted bit is driven at frame entry.
  logic mosi_entry;
  assign mosi_entry = (state_q == IDLE) && (state_d == FRAME_A) ? shreg_d[WORD_W-1] : mosi_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      slot_q   <= '0;
      shreg_q  <= '0;
      rx_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      if_rdata <= '0;
      if_done  <= 1'b0;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      slot_q   <= slot_d;
      shreg_q  <= shreg_d;
      rx_q     <= rx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      if_rdata <= rdata_d;
      if_done  <= done_d;
      spi_sclk <= sclk_d;
      spi_cs_n <= cs_n_d;
      spi_mosi <= mosi_entry;
    end
  end

endmodule

// File: tb/tb_pll_spi_master.sv
// Scoreboard bench for pll_spi_master: expected frames are queued as commands
// are issued and compared when the SPI monitor sees each frame close.
module tb_pll_spi_master;

  typedef struct packed {
    logic [15:0] word;
    logic        first;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       if_reset = 1'b1;
  logic       if_reset1 = 1'b1;
  logic       if_read = 1'b0;
  logic       if_write = 1'b0;
  logic [7:0] if_addr = 8'h00;
  logic [7:0] if_wdata = 8'h00;
  logic [7:0] if_rdata, if_rdata1;
  logic       if_done, if_done1;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_sclk1, spi_cs_n1, spi_mosi1;
  logic       spi_miso = 1'b0;
  logic       spi_miso1 = 1'b0;

  int total = 0;
  int bad = 0;

  frame_t      exp_q[$];
  logic [15:0] miso_word = 16'h3CA5;
  logic [15:0] rx_word = '0;
  int          low_cnt = 0, pulses = 0, rise_cnt = 0, gap_cnt = 0, frames_seen = 0;
  logic        gap_arm = 1'b0, skip_frame = 1'b0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0;
  int          low1 = 0, falls1 = 0, pulses1 = 0;
  logic        cs1_prev = 1'b1, sclk1_prev = 1'b0;

  pll_spi_master u_dut (
    .clk(clk), .reset(reset), .if_reset(if_reset), .if_read(if_read), .if_write(if_write),
    .if_addr(if_addr), .if_wdata(if_wdata), .if_rdata(if_rdata), .if_done(if_done),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  pll_spi_master #(.CLK_DIV(1), .CS_GAP(4)) u_dut1 (
    .clk(clk), .reset(reset), .if_reset(if_reset1), .if_read(if_read), .if_write(if_write),
    .if_addr(if_addr), .if_wdata(if_wdata), .if_rdata(if_rdata1), .if_done(if_done1),
    .spi_sclk(spi_sclk1), .spi_cs_n(spi_cs_n1), .spi_mosi(spi_mosi1), .spi_miso(spi_miso1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // SPI monitor and mode-0 slave model for the default-divider instance.
  always @(negedge clk) begin
    frame_t f;
    if (!spi_cs_n && cs_prev) begin
      low_cnt = 0; pulses = 0; rise_cnt = 0; rx_word = '0;
      frames_seen++;
      if (gap_arm) begin
        check("cs_gap", gap_cnt, 4);
        gap_arm = 1'b0;
      end
    end
    if (!spi_cs_n) begin
      low_cnt++;
      if (spi_sclk && !sclk_prev) begin
        rx_word = {rx_word[14:0], spi_mosi};
        pulses++;
        rise_cnt++;
      end
    end else if (gap_arm) begin
      gap_cnt++;
    end
    if (spi_cs_n && !cs_prev) begin
      if (skip_frame) begin
        skip_frame = 1'b0;
      end else if (exp_q.size() == 0) begin
        check("frame_expected", exp_q.size(), 1);
      end else begin
        f = exp_q.pop_front();
        check("mosi_word", rx_word, f.word);
        check("sclk_pulses", pulses, 16);
        check("cs_low_cycles", low_cnt, 136);
        if (f.first) begin
          gap_arm = 1'b1;
          gap_cnt = 1;
        end
      end
    end
    spi_miso = (!spi_cs_n && rise_cnt < 16) ? miso_word[15 - rise_cnt] : 1'b0;
    sclk_prev = spi_sclk;
    cs_prev = spi_cs_n;
  end

  // Frame monitor for the CLK_DIV=1 instance.
  always @(negedge clk) begin
    if (!spi_cs_n1 && cs1_prev) begin
      falls1++;
      low1 = 0;
    end
    if (!spi_cs_n1) low1++;
    if (spi_cs_n1 && !cs1_prev) check("div1_cs_low", low1, 34);
    if (!spi_cs_n1 && spi_sclk1 && !sclk1_prev) pulses1++;
    cs1_prev = spi_cs_n1;
    sclk1_prev = spi_sclk1;
  end

  task automatic wait_done(output int lat);
    int n;
    @(posedge clk); #1;
    n = 1;
    if_addr = 8'($urandom);
    if_wdata = 8'($urandom);
    if_read = 1'($urandom);
    if_write = 1'($urandom);
    while (!if_done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!if_done) check("done_timeout", if_done, 1);
    lat = n - 1;
  endtask

  task automatic run_cmd(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input int exp_lat,
                         input logic [7:0] exp_rdata, input int hold);
    int lat, ones, act, f0;
    frame_t fr;
    if_read = rd; if_write = wr; if_addr = addr; if_wdata = wdata;
    f0 = frames_seen;
    if (rd || wr) begin
      fr.word = {8'h00, addr}; fr.first = 1'b1; exp_q.push_back(fr);
      fr.word = wr ? {8'h40, wdata} : 16'h8000; fr.first = 1'b0; exp_q.push_back(fr);
    end
    if_reset = 1'b0;
    wait_done(lat);
    check("done_latency", lat, exp_lat);
    check("rdata", if_rdata, exp_rdata);
    ones = 0; act = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (if_done) ones++;
      if (!spi_cs_n || spi_sclk) act++;
    end
    if (hold > 0) begin
      check("hold_done", ones, hold);
      check("hold_spi_idle", act, 0);
    end
    if_reset = 1'b1;
    @(posedge clk); #1;
    check("done_fall", if_done, 0);
    check("frames_left", exp_q.size(), 0);
    check("frame_count", frames_seen - f0, (rd || wr) ? 2 : 0);
  endtask

  initial begin
    frame_t fr;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", if_rdata, 8'h00);
    check("rst_done", if_done, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_cmd(1'b0, 1'b1, 8'h01, 8'h09, 276, 8'h00, 0);
    run_cmd(1'b1, 1'b0, 8'h02, 8'h00, 276, 8'hA5, 50);
    run_cmd(1'b0, 1'b1, 8'h07, 8'h33, 276, 8'hA5, 0);
    run_cmd(1'b1, 1'b1, 8'h03, 8'h5A, 276, 8'hA5, 0);
    run_cmd(1'b0, 1'b0, 8'h04, 8'h00, 1, 8'hA5, 0);

    // Abort in the middle of the data frame of a read.
    miso_word = 16'h0042;
    if_read = 1'b1; if_write = 1'b0; if_addr = 8'h10; if_wdata = 8'h00;
    fr.word = 16'h0010; fr.first = 1'b1; exp_q.push_back(fr);
    fr.word = 16'h8000; fr.first = 1'b0; exp_q.push_back(fr);
    if_reset = 1'b0;
    @(posedge clk);
    repeat (180) @(posedge clk);
    #1;
    skip_frame = 1'b1;
    if_reset = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_done", if_done, 0);
    check("abort_rdata", if_rdata, 8'hA5);
    @(negedge clk);
    exp_q.delete();
    gap_arm = 1'b0;
    @(posedge clk); #1;
    miso_word = 16'h005E;
    run_cmd(1'b1, 1'b0, 8'h11, 8'h00, 276, 8'h5E, 0);

    // Synchronous reset in the middle of a frame.
    if_read = 1'b0; if_write = 1'b1; if_addr = 8'h20; if_wdata = 8'h77;
    fr.word = 16'h0020; fr.first = 1'b1; exp_q.push_back(fr);
    if_reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    skip_frame = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_cs_n", spi_cs_n, 1);
    check("mrst_sclk", spi_sclk, 0);
    check("mrst_mosi", spi_mosi, 0);
    check("mrst_done", if_done, 0);
    check("mrst_rdata", if_rdata, 8'h00);
    if_reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    gap_arm = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fastest divider.
    falls1 = 0; pulses1 = 0;
    if_read = 1'b0; if_write = 1'b1; if_addr = 8'h01; if_wdata = 8'h09;
    if_reset1 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!if_done1 && n < 500);
    check("div1_latency", n - 1, 72);
    check("div1_frames", falls1, 2);
    check("div1_pulses", pulses1, 32);
    if_reset1 = 1'b1;
    @(posedge clk); #1;
    check("div1_done_fall", if_done1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
